// File: rtl/calc2_top.sv
// Four-port integer calculator: each port feeds a 4-deep request FIFO, and the FIFO
// heads share one add/sub unit and one shift unit. Results return on the originating port.
module calc2_top (
  output logic [0:31] out_data1,
  output logic [0:31] out_data2,
  output logic [0:31] out_data3,
  output logic [0:31] out_data4,
  output logic [0:1]  out_resp1,
  output logic [0:1]  out_resp2,
  output logic [0:1]  out_resp3,
  output logic [0:1]  out_resp4,
  output logic [0:1]  out_tag1,
  output logic [0:1]  out_tag2,
  output logic [0:1]  out_tag3,
  output logic [0:1]  out_tag4,
  output logic        scan_out,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        c_clk,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:1]  req1_tag_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:1]  req2_tag_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:1]  req3_tag_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  input  logic [0:1]  req4_tag_in,
  input  logic        reset,
  input  logic        scan_in
);
  localparam int         DATA_W   = 32;
  localparam int         NPORT    = 4;
  localparam int         DEPTH    = 4;
  localparam logic [2:0] FULL     = 3'd4;
  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_ERR = 2'd2;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  function automatic logic [DATA_W+1:0] addsub_f(input logic [3:0] cmd,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] wide;
    if (cmd == CMD_ADD) wide = {1'b0, a} + {1'b0, b};
    else                wide = {1'b0, a} - {1'b0, b};
    // Carry out of an add and borrow out of a subtract both land in the top bit.
    if (wide[DATA_W]) return {RESP_ERR, {DATA_W{1'b0}}};
    return {RESP_OK, wide[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W+1:0] shift_f(input logic [3:0] cmd,
                                                input logic [DATA_W-1:0] a,
                                                input logic [4:0] amt);
    if (cmd == CMD_SHL) return {RESP_OK, a << amt};
    return {RESP_OK, a >> amt};
  endfunction

  logic [3:0]        cmd_in  [NPORT];
  logic [DATA_W-1:0] data_in [NPORT];
  logic [1:0]        tag_in  [NPORT];

  assign cmd_in[0] = req1_cmd_in;  assign data_in[0] = req1_data_in;  assign tag_in[0] = req1_tag_in;
  assign cmd_in[1] = req2_cmd_in;  assign data_in[1] = req2_data_in;  assign tag_in[1] = req2_tag_in;
  assign cmd_in[2] = req3_cmd_in;  assign data_in[2] = req3_data_in;  assign tag_in[2] = req3_tag_in;
  assign cmd_in[3] = req4_cmd_in;  assign data_in[3] = req4_data_in;  assign tag_in[3] = req4_tag_in;

  logic [NPORT-1:0]  phase_q, phase_d;
  logic [3:0]        pend_cmd_q [NPORT];
  logic [DATA_W-1:0] pend_op1_q [NPORT];
  logic [1:0]        pend_tag_q [NPORT];

  logic [3:0]        fifo_cmd_q [NPORT][DEPTH];
  logic [DATA_W-1:0] fifo_op1_q [NPORT][DEPTH];
  logic [DATA_W-1:0] fifo_op2_q [NPORT][DEPTH];
  logic [1:0]        fifo_tag_q [NPORT][DEPTH];
  logic [1:0]        wr_ptr_q [NPORT], wr_ptr_d [NPORT];
  logic [1:0]        rd_ptr_q [NPORT], rd_ptr_d [NPORT];
  logic [2:0]        cnt_q    [NPORT], cnt_d    [NPORT];

  logic [1:0]        resp_q [NPORT], resp_d [NPORT];
  logic [DATA_W-1:0] data_q [NPORT], data_d [NPORT];
  logic [1:0]        otag_q [NPORT], otag_d [NPORT];

  logic [NPORT-1:0]  cap, enq, retire, as_gnt, sh_gnt, inv_head;
  logic [3:0]        head_cmd [NPORT];
  logic [DATA_W-1:0] head_op1 [NPORT];
  logic [DATA_W-1:0] head_op2 [NPORT];
  logic [1:0]        head_tag [NPORT];

  logic [3:0]        as_cmd, sh_cmd;
  logic [DATA_W-1:0] as_a, as_b, sh_a;
  logic [4:0]        sh_amt;
  logic [DATA_W+1:0] as_res, sh_res;

  // Request capture: operand 1 is held for a cycle, operand 2 completes the entry.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      cap[p]      = !phase_q[p] && (cmd_in[p] != 4'd0);
      enq[p]      = phase_q[p] && (cnt_q[p] != FULL);
      head_cmd[p] = fifo_cmd_q[p][rd_ptr_q[p]];
      head_op1[p] = fifo_op1_q[p][rd_ptr_q[p]];
      head_op2[p] = fifo_op2_q[p][rd_ptr_q[p]];
      head_tag[p] = fifo_tag_q[p][rd_ptr_q[p]];
    end
  end

  assign phase_d = cap;

  // Dispatch: lowest-numbered eligible head wins each unit; invalid heads retire alone.
  always_comb begin
    as_gnt   = '0;
    sh_gnt   = '0;
    inv_head = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (cnt_q[p] != 3'd0) begin
        if (head_cmd[p] == CMD_ADD || head_cmd[p] == CMD_SUB) begin
          if (as_gnt == '0) as_gnt[p] = 1'b1;
        end else if (head_cmd[p] == CMD_SHL || head_cmd[p] == CMD_SHR) begin
          if (sh_gnt == '0) sh_gnt[p] = 1'b1;
        end else begin
          inv_head[p] = 1'b1;
        end
      end
    end
  end

  assign retire = as_gnt | sh_gnt | inv_head;

  always_comb begin
    as_cmd = CMD_ADD;
    as_a   = '0;
    as_b   = '0;
    sh_cmd = CMD_SHL;
    sh_a   = '0;
    sh_amt = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (as_gnt[p]) begin
        as_cmd = head_cmd[p];
        as_a   = head_op1[p];
        as_b   = head_op2[p];
      end
      if (sh_gnt[p]) begin
        sh_cmd = head_cmd[p];
        sh_a   = head_op1[p];
        sh_amt = head_op2[p][4:0];
      end
    end
  end

  assign as_res = addsub_f(as_cmd, as_a, as_b);
  assign sh_res = shift_f(sh_cmd, sh_a, sh_amt);

  // Result stage: a port with nothing retiring presents all-zero outputs.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      resp_d[p] = 2'd0;
      data_d[p] = '0;
      otag_d[p] = 2'd0;
      if (as_gnt[p])        {resp_d[p], data_d[p]} = as_res;
      else if (sh_gnt[p])   {resp_d[p], data_d[p]} = sh_res;
      else if (inv_head[p]) resp_d[p] = RESP_ERR;
      if (retire[p]) otag_d[p] = head_tag[p];
      wr_ptr_d[p] = wr_ptr_q[p] + {1'b0, enq[p]};
      rd_ptr_d[p] = rd_ptr_q[p] + {1'b0, retire[p]};
      cnt_d[p]    = cnt_q[p] + {2'b0, enq[p]} - {2'b0, retire[p]};
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      phase_q <= '0;
      for (int p = 0; p < NPORT; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
        resp_q[p]   <= '0;
        data_q[p]   <= '0;
        otag_q[p]   <= '0;
      end
    end else begin
      phase_q <= phase_d;
      for (int p = 0; p < NPORT; p++) begin
        wr_ptr_q[p] <= wr_ptr_d[p];
        rd_ptr_q[p] <= rd_ptr_d[p];
        cnt_q[p]    <= cnt_d[p];
        resp_q[p]   <= resp_d[p];
        data_q[p]   <= data_d[p];
        otag_q[p]   <= otag_d[p];
      end
    end
  end

  // Payload storage carries no reset; pointers and counts decide what is live.
  always_ff @(posedge c_clk) begin
    for (int p = 0; p < NPORT; p++) begin
      if (cap[p]) begin
        pend_cmd_q[p] <= cmd_in[p];
        pend_op1_q[p] <= data_in[p];
        pend_tag_q[p] <= tag_in[p];
      end
      if (enq[p]) begin
        fifo_cmd_q[p][wr_ptr_q[p]] <= pend_cmd_q[p];
        fifo_op1_q[p][wr_ptr_q[p]] <= pend_op1_q[p];
        fifo_op2_q[p][wr_ptr_q[p]] <= data_in[p];
        fifo_tag_q[p][wr_ptr_q[p]] <= pend_tag_q[p];
      end
    end
  end

  assign out_data1 = data_q[0];  assign out_resp1 = resp_q[0];  assign out_tag1 = otag_q[0];
  assign out_data2 = data_q[1];  assign out_resp2 = resp_q[1];  assign out_tag2 = otag_q[1];
  assign out_data3 = data_q[2];  assign out_resp3 = resp_q[2];  assign out_tag3 = otag_q[2];
  assign out_data4 = data_q[3];  assign out_resp4 = resp_q[3];  assign out_tag4 = otag_q[3];

  // Scan pins are present for DFT hookup only.
  logic unused_scan;
  assign unused_scan = a_clk ^ b_clk ^ scan_in;
  assign scan_out    = 1'b0;

endmodule

// File: tb/tb_calc2_top.sv
// Scoreboard bench for calc2_top: the driver pushes model results per port, a
// negedge monitor pops and compares whenever a port shows a nonzero response.
module tb_calc2_top;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
    int          cyc;
  } exp_t;

  logic        c_clk = 1'b0;
  logic        a_clk = 1'b0;
  logic        b_clk = 1'b0;
  logic        scan_in = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [1:0]  tg  [4];

  logic [31:0] out_data1, out_data2, out_data3, out_data4;
  logic [1:0]  out_resp1, out_resp2, out_resp3, out_resp4;
  logic [1:0]  out_tag1, out_tag2, out_tag3, out_tag4;
  logic        scan_out;

  logic [31:0] o_d [4];
  logic [1:0]  o_r [4];
  logic [1:0]  o_t [4];
  assign o_d[0] = out_data1;  assign o_r[0] = out_resp1;  assign o_t[0] = out_tag1;
  assign o_d[1] = out_data2;  assign o_r[1] = out_resp2;  assign o_t[1] = out_tag2;
  assign o_d[2] = out_data3;  assign o_r[2] = out_resp3;  assign o_t[2] = out_tag3;
  assign o_d[3] = out_data4;  assign o_r[3] = out_resp4;  assign o_t[3] = out_tag4;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  calc2_top dut (
    .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3), .out_data4(out_data4),
    .out_resp1(out_resp1), .out_resp2(out_resp2), .out_resp3(out_resp3), .out_resp4(out_resp4),
    .out_tag1(out_tag1), .out_tag2(out_tag2), .out_tag3(out_tag3), .out_tag4(out_tag4),
    .scan_out(scan_out), .a_clk(a_clk), .b_clk(b_clk), .c_clk(c_clk),
    .req1_cmd_in(cmd[0]), .req1_data_in(dat[0]), .req1_tag_in(tg[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(dat[1]), .req2_tag_in(tg[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(dat[2]), .req3_tag_in(tg[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(dat[3]), .req4_tag_in(tg[3]),
    .reset(reset), .scan_in(scan_in)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  exp_t q0[$], q1[$], q2[$], q3[$];

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpush(input int p, input exp_t e);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic qpop(input int p, output exp_t e);
    case (p)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  task automatic qflush();
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
  endtask

  // Reference model: the arithmetic rules as plain unsigned math.
  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] t);
    exp_t e;
    logic [63:0] s;
    e.tag = t; e.cyc = -1; e.resp = 2'd2; e.data = 32'd0;
    case (c)
      4'd1: begin
        s = {32'd0, a} + {32'd0, b};
        if (s <= 64'hFFFF_FFFF) begin e.resp = 2'd1; e.data = a + b; end
      end
      4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << (b % 32); end
      4'd6: begin e.resp = 2'd1; e.data = a >> (b % 32); end
      default: ;
    endcase
    return e;
  endfunction

  logic [3:0]  st_c  [4];
  logic [31:0] st_a  [4];
  logic [31:0] st_b  [4];
  logic [1:0]  st_t  [4];
  int          st_lat[4];
  logic [1:0]  st_xr [4];
  logic [31:0] st_xd [4];
  bit          st_drop[4];

  task automatic clear_stage();
    for (int p = 0; p < 4; p++) begin
      st_c[p] = 4'd0; st_a[p] = 32'd0; st_b[p] = 32'd0; st_t[p] = 2'd0;
      st_lat[p] = 0; st_xr[p] = 2'd0; st_xd[p] = 32'd0; st_drop[p] = 1'b0;
    end
  endtask

  // xr != 0 supplies an explicit expected resp/data instead of the model; lat 0 = untimed.
  task automatic stage(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] t, input int lat, input logic [1:0] xr,
                       input logic [31:0] xd, input bit drop);
    st_c[p] = c; st_a[p] = a; st_b[p] = b; st_t[p] = t;
    st_lat[p] = lat; st_xr[p] = xr; st_xd[p] = xd; st_drop[p] = drop;
  endtask

  // Two-cycle issue of everything staged; expectations are pushed as operand 2 goes out.
  task automatic go();
    int n;
    exp_t e;
    @(posedge c_clk); #1;
    n = cyc;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = st_c[p]; dat[p] = st_a[p]; tg[p] = st_t[p];
    end
    @(posedge c_clk); #1;
    for (int p = 0; p < 4; p++) begin
      dat[p] = st_b[p];
      if (st_c[p] != 4'd0) begin
        cmd[p] = 4'($urandom_range(0, 15));
        tg[p]  = 2'($urandom_range(0, 3));
      end else begin
        cmd[p] = 4'd0;
        tg[p]  = 2'd0;
      end
      if (st_c[p] != 4'd0 && !st_drop[p]) begin
        e = model(st_c[p], st_a[p], st_b[p], st_t[p]);
        if (st_xr[p] != 2'd0) begin e.resp = st_xr[p]; e.data = st_xd[p]; end
        e.cyc = (st_lat[p] > 0) ? n + st_lat[p] : -1;
        qpush(p, e);
      end
    end
    clear_stage();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge c_clk); #1;
      for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; tg[p] = 2'd0; dat[p] = 32'd0; end
    end
  endtask

  task automatic check_zero(input string nm);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (o_r[p] !== 2'd0 || o_d[p] !== 32'd0 || o_t[p] !== 2'd0) begin
        errors++;
        $display("FAIL %s port%0d got resp=%0d data=%h tag=%0d, required all zero",
                 nm, p + 1, o_r[p], o_d[p], o_t[p]);
      end
    end
    checks++;
    if (scan_out !== 1'b0) begin
      errors++;
      $display("FAIL %s scan_out got %b, required 0", nm, scan_out);
    end
  endtask

  function automatic logic [3:0] rcmd();
    case ($urandom_range(0, 9))
      0, 1: return 4'd1;
      2, 3: return 4'd2;
      4, 5: return 4'd5;
      6, 7: return 4'd6;
      8:    return 4'd3;
      default: return 4'(($urandom_range(0, 1) == 1) ? 7 : 12);
    endcase
  endfunction

  function automatic logic [31:0] rop();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 255));
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
      default: return 32'h8000_0000 + 32'($urandom_range(0, 3));
    endcase
  endfunction

  // Monitor
  always @(negedge c_clk) begin
    exp_t e;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (o_r[p] != 2'd0) begin
          if (qsize(p) == 0) begin
            errors++;
            $display("FAIL unexpected port%0d cycle %0d got resp=%0d data=%h tag=%0d, required no response",
                     p + 1, cyc, o_r[p], o_d[p], o_t[p]);
          end else begin
            qpop(p, e);
            if (o_r[p] !== e.resp || o_d[p] !== e.data || o_t[p] !== e.tag) begin
              errors++;
              $display("FAIL result port%0d cycle %0d got resp=%0d data=%h tag=%0d, required resp=%0d data=%h tag=%0d",
                       p + 1, cyc, o_r[p], o_d[p], o_t[p], e.resp, e.data, e.tag);
            end
            if (e.cyc >= 0) begin
              checks++;
              if (cyc != e.cyc) begin
                errors++;
                $display("FAIL latency port%0d got cycle %0d, required cycle %0d", p + 1, cyc, e.cyc);
              end
            end
          end
        end else if (o_d[p] !== 32'd0 || o_t[p] !== 2'd0) begin
          errors++;
          $display("FAIL idle_zero port%0d cycle %0d got data=%h tag=%0d, required 0",
                   p + 1, cyc, o_d[p], o_t[p]);
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; dat[p] = 32'd0; tg[p] = 2'd0; end
    clear_stage();
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    check_zero("reset_state");
    @(posedge c_clk); #1;
    reset = 1'b0;
    idle(2);

    // Adds on all ports at once: the shared unit serialises them by port number.
    stage(0, 4'd1, 32'd10, 32'd25, 2'd1, 3, 2'd1, 32'd35, 0);
    stage(1, 4'd1, 32'd1000000, 32'd2000000, 2'd1, 4, 2'd1, 32'd3000000, 0);
    stage(2, 4'd1, 32'h7FFF_FFFE, 32'd2, 2'd1, 5, 2'd1, 32'h8000_0000, 0);
    stage(3, 4'd1, 32'h001F_FFFE, 32'd5, 2'd1, 6, 2'd1, 32'h0020_0003, 0);
    go();
    idle(8);

    // Subtracts, one port at a time.
    stage(0, 4'd2, 32'd5, 32'd5, 2'd2, 3, 2'd1, 32'd0, 0);             go();
    stage(1, 4'd2, 32'd10, 32'd9, 2'd2, 3, 2'd1, 32'd1, 0);            go();
    stage(2, 4'd2, 32'd50000, 32'd1999, 2'd2, 3, 2'd1, 32'd48001, 0);  go();
    stage(3, 4'd2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'd2, 3, 2'd1, 32'd0, 0); go();
    stage(0, 4'd2, 32'd5, 32'd10, 2'd2, 3, 2'd2, 32'd0, 0);            go();
    idle(6);

    // Add overflow.
    stage(0, 4'd1, 32'hFFFF_FFFF, 32'd1, 2'd1, 3, 2'd2, 32'd0, 0);
    go();
    idle(6);

    // Shifts.
    stage(0, 4'd5, 32'h1F, 32'd2, 2'd0, 3, 2'd1, 32'd124, 0);                 go();
    stage(1, 4'd5, 32'h7FFF_FFFE, 32'd20, 2'd1, 3, 2'd1, 32'hFFE0_0000, 0);   go();
    stage(2, 4'd6, 32'h7FFF_FFFF, 32'd2, 2'd2, 3, 2'd1, 32'h1FFF_FFFF, 0);    go();
    stage(3, 4'd6, 32'hFFFF_FFFF, 32'd10, 2'd3, 3, 2'd1, 32'h003F_FFFF, 0);   go();
    stage(0, 4'd5, 32'h1234_5678, 32'd32, 2'd1, 3, 2'd1, 32'h1234_5678, 0);   go();
    stage(1, 4'd6, 32'hCAFE_F00D, 32'd32, 2'd1, 3, 2'd1, 32'hCAFE_F00D, 0);   go();
    idle(6);

    // Invalid commands beside concurrent adds: no unit is consumed.
    stage(0, 4'd3, $urandom, $urandom, 2'd3, 3, 2'd2, 32'd0, 0);
    stage(1, 4'd1, 32'd7, 32'd8, 2'd0, 3, 2'd1, 32'd15, 0);
    go();
    stage(2, 4'd7, $urandom, $urandom, 2'd3, 3, 2'd2, 32'd0, 0);
    stage(3, 4'd1, 32'd100, 32'd23, 2'd2, 3, 2'd1, 32'd123, 0);
    go();
    idle(6);

    // Add and shift issued together both complete uncontended.
    stage(0, 4'd1, 32'd40, 32'd2, 2'd1, 3, 2'd1, 32'd42, 0);
    stage(1, 4'd5, 32'd3, 32'd4, 2'd2, 3, 2'd1, 32'd48, 0);
    go();
    idle(6);

    // Ports 1 and 2 saturate the adder while port 4 queues five adds; the fifth is dropped.
    for (int k = 0; k < 12; k++) begin
      stage(0, 4'd1, 32'(k), 32'd1000, 2'(k), 3, 2'd0, 32'd0, 0);
      stage(1, 4'd1, 32'(k), 32'd2000, 2'(k + 1), 4, 2'd0, 32'd0, 0);
      if (k < 5) stage(3, 4'd1, 32'(100 + k), 32'(k), 2'(k), 0, 2'd0, 32'd0, k == 4);
      go();
    end
    idle(20);

    // Randomised traffic, keeping each port within its outstanding limit.
    for (int k = 0; k < 80; k++) begin
      for (int p = 0; p < 4; p++)
        if ($urandom_range(0, 1) == 1 && qsize(p) < 4)
          stage(p, rcmd(), rop(), rop(), 2'($urandom_range(0, 3)), 0, 2'd0, 32'd0, 0);
      go();
    end
    idle(40);

    // Reset with requests queued and in flight.
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 4; p++) stage(p, 4'd1, 32'(k + p), 32'd77, 2'(p), 0, 2'd0, 32'd0, 0);
      go();
    end
    @(posedge c_clk); #1;
    reset = 1'b1;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; tg[p] = 2'd0; dat[p] = 32'd0; end
    @(posedge c_clk); #1;
    qflush();
    @(negedge c_clk);
    check_zero("reset_mid");
    @(posedge c_clk); #1;
    reset = 1'b0;
    idle(20);
    stage(2, 4'd1, 32'd9, 32'd9, 2'd3, 3, 2'd1, 32'd18, 0);
    go();
    idle(6);

    for (int k = 0; k < 200 && (qsize(0) + qsize(1) + qsize(2) + qsize(3)) != 0; k++)
      @(posedge c_clk);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (qsize(p) != 0) begin
        errors++;
        $display("FAIL drain port%0d got %0d responses outstanding, required 0", p + 1, qsize(p));
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
